// File: rtl/in_port_ctrl.sv
// Input port controller: buffers words from an external device and hands them to the
// pipeline on IN instructions.
// Optional build macro IN_PORT_STALL_EN: when defined, an IN at an empty buffer stalls
// the pipeline until a word arrives. When undefined, such an IN is acknowledged at once
// and in_data repeats its last value.
module in_port_ctrl #(
    parameter int unsigned Width = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [Width-1:0]         dev_data,
    input  logic                     dev_valid,
    output logic                     dev_ready,
    input  logic                     in_req,
    input  logic                     flush,
    output logic [Width-1:0]         in_data,
    output logic                     in_ack,
    output logic                     stall,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = PtrW + 1;

    logic [Width-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]  level_q, level_d;
    logic [Width-1:0] in_data_q, in_data_d;
    logic             in_ack_q, in_ack_d;
    logic             full, empty, push, pop;

`ifdef IN_PORT_STALL_EN
    typedef enum logic [0:0] {StIdle, StWait} state_e;
    state_e state_q, state_d;
`endif

    assign full      = (level_q == LvlW'(DEPTH));
    assign empty     = (level_q == '0);
    assign dev_ready = !full && !rst;
    assign push      = dev_valid && dev_ready;

    // Decide whether to pop this cycle and whether an ack follows; the FSM only exists with stalls.
    always_comb begin
        pop      = 1'b0;
        in_ack_d = 1'b0;
`ifdef IN_PORT_STALL_EN
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (in_req && !flush) begin
                    if (!empty) pop = 1'b1;
                    else        state_d = StWait;
                end
            end
            StWait: begin
                // in_req is ignored here; only flush or arriving data leave WAIT
                if (flush) begin
                    state_d = StIdle;
                end else if (!empty) begin
                    pop     = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        in_ack_d = pop;
`else
        // Without stalls an empty-buffer IN is still acked, with in_data left as it was
        if (in_req && !flush) begin
            pop      = !empty;
            in_ack_d = 1'b1;
        end
`endif
    end

    // Buffer pointers, occupancy and delivered word; level uses the registered count so
    // a word pushed at one edge cannot be popped at that same edge.
    always_comb begin
        wr_ptr_d  = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        in_data_d = pop  ? mem_q[rd_ptr_q] : in_data_q;
        level_d   = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LvlW'(1);
            2'b01:   level_d = level_q - LvlW'(1);
            default: level_d = level_q;
        endcase
    end

    // Control and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            in_data_q <= '0;
            in_ack_q  <= 1'b0;
`ifdef IN_PORT_STALL_EN
            state_q   <= StIdle;
`endif
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            in_data_q <= in_data_d;
            in_ack_q  <= in_ack_d;
`ifdef IN_PORT_STALL_EN
            state_q   <= state_d;
`endif
        end
    end

    // Storage array; not reset, since reset empties it by clearing the pointers.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= dev_data;
    end

    assign in_data = in_data_q;
    assign in_ack  = in_ack_q;
    assign level   = level_q;
`ifdef IN_PORT_STALL_EN
    assign stall   = (state_q == StWait);
`else
    assign stall   = 1'b0;
`endif

endmodule

// File: doc/in_port_ctrl.md
IN_PORT_CTRL -- requirements
Module: in_port_ctrl

Interface
REQ-001 The block SHALL have parameter Width, default 16, meaning input port data width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning input buffer entries; power of two, at least 2.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port dev_data, input, Width, external device word.
REQ-006 The block SHALL have port dev_valid, input, 1, device offers dev_data this cycle.
REQ-007 The block SHALL have port dev_ready, output, 1, buffer accepts a word this cycle.
REQ-008 The block SHALL have port in_req, input, 1, one-cycle pulse from execute stage for an IN instruction.
REQ-009 The block SHALL have port flush, input, 1, pipeline flush cancels a pending IN.
REQ-010 The block SHALL have port in_data, output, Width, value delivered to the pipeline.
REQ-011 The block SHALL have port in_ack, output, 1, one-cycle pulse qualifying in_data.
REQ-012 The block SHALL have port stall, output, 1, freezes fetch/decode/execute while an IN waits for data.
REQ-013 The block SHALL have port level, output, log2(DEPTH)+1, current buffer occupancy.

Function
REQ-014 The block SHALL drive dev_ready = not full and not rst, combinationally.
REQ-015 The block SHALL push dev_data on a rising edge where dev_valid and dev_ready are both 1; write pointer wraps modulo DEPTH.
REQ-016 The block SHALL have no bypass: a word pushed at edge N is poppable no earlier than edge N+1.
REQ-017 The block SHALL implement states IDLE and WAIT.
REQ-018 In IDLE, when in_req=1, flush=0 and level>0 at edge N, the block SHALL pop the head into in_data and pulse in_ack=1 for cycle N+1 only.
REQ-019 In IDLE, when in_req=1, flush=0 and level=0, the block SHALL enter WAIT with stall=1 from cycle N+1.
REQ-020 In WAIT, at the first edge with level>0, the block SHALL pop, pulse in_ack with the popped word, drop stall and return to IDLE in the same next cycle.
REQ-021 In WAIT, in_req SHALL be ignored.
REQ-022 When flush=1 in any state, the block SHALL drop any same-cycle in_req, return to IDLE, clear stall next cycle, and leave buffer contents unchanged.
REQ-023 Simultaneous push and pop SHALL keep level unchanged; the read pointer wraps modulo DEPTH.
REQ-024 in_data SHALL hold its last delivered value between acks.
REQ-025 level SHALL never exceed DEPTH and never go below 0.

Reset
REQ-026 With rst=1 at an edge, the block SHALL set the state to IDLE, both pointers and level to 0, in_data to 0, in_ack to 0 and stall to 0.
REQ-027 Reset during WAIT SHALL abandon the pending IN and discard buffered words.
REQ-028 No push SHALL occur while rst=1.

Configuration
REQ-029 With macro IN_PORT_STALL_EN defined, the block SHALL behave per REQ-019 to REQ-021.
REQ-030 Without IN_PORT_STALL_EN, the block SHALL exclude WAIT and tie stall to 0.
REQ-031 Without IN_PORT_STALL_EN, in_req with level=0 SHALL pulse in_ack in cycle N+1 with in_data unchanged, repeating the last value or 0 after reset.

Verification
REQ-032 Scenario: reset, push 0x1234, in_req two cycles later -> in_ack next cycle with in_data=0x1234, level returns to 0.
REQ-033 Scenario: push 0x0001..0x0004 in four consecutive cycles -> level=4, dev_ready=0; a further dev_valid is not accepted; four in_req pulses return 1, 2, 3, 4 in order, covering wrap.
REQ-034 Scenario (STALL_EN): in_req at empty -> stall=1; push 0xBEEF three cycles later -> in_ack with 0xBEEF on the second cycle after the push, stall=0 in that same cycle.
REQ-035 Scenario (STALL_EN): in WAIT, assert flush -> stall=0 next cycle, no in_ack; a later push of 0x00AA stays buffered with level=1.
REQ-036 Scenario: level=4 with in_req and dev_valid in the same cycle -> pop only (dev_ready=0), level=3; at level=2, push and pop together -> level stays 2.
REQ-037 Scenario (no STALL_EN): in_req at empty after reset -> in_ack=1, in_data=0x0000, stall remains 0.
